// File: rtl/sram_bist_master.sv
// BIST master for the 1024x32 single-port SRAM: writes a pattern to every
// word, reads it back with one-cycle latency and reports the mismatches.
module sram_bist_master #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024,
   parameter logic [31:0] SEED   = 32'hA5A55A5A
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        pattern_sel,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] avm_address,
   output logic [3:0]        avm_byteenable,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic              avm_clken,
   input  logic [31:0]       avm_readdata
);

   localparam logic [31:0]       POLY = 32'h80200003;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN
   } state_e;

   state_e state_q, state_d;

   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [31:0]       lfsr_q, lfsr_d;
   logic [1:0]        pat_q, pat_d;
   logic              pv_q, pv_d;
   logic [31:0]       pexp_q, pexp_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [15:0]       err_q, err_d;
   logic [ADDR_W-1:0] ferr_q, ferr_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              clken_q;

   logic              accept;
   logic              is_last;
   logic              mism;
   logic [31:0]       cur_pat;

   function automatic logic [31:0] pat_f(
      input logic [1:0]        sel,
      input logic [ADDR_W-1:0] k,
      input logic [31:0]       l
   );
      logic [15:0] k16;
      k16 = 16'(k);
      unique case (sel)
         2'd0:    pat_f = {k16, k16};
         2'd1:    pat_f = k[0] ? 32'hAAAAAAAA : 32'h55555555;
         2'd2:    pat_f = l;
         default: pat_f = 32'hFFFFFFFF;
      endcase
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] l);
      lfsr_next = (l >> 1) ^ (l[0] ? POLY : 32'h0);
   endfunction

   assign accept  = (state_q == S_IDLE) && start && !abort;
   assign is_last = (cnt_q == LAST);
   assign cur_pat = pat_f(pat_q, cnt_q, lfsr_q);
   assign mism    = pv_q && !abort && (avm_readdata != pexp_q);

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (abort)        state_d = S_IDLE;
            else if (is_last) state_d = S_READ;
         end
         S_READ: begin
            if (abort)        state_d = S_IDLE;
            else if (is_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // outputs toward the SRAM
   always_comb begin
      busy           = (state_q != S_IDLE);
      avm_address    = '0;
      avm_byteenable = 4'h0;
      avm_chipselect = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = 32'h0;
      unique case (state_q)
         S_WRITE: begin
            avm_address    = cnt_q;
            avm_byteenable = 4'hF;
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
            avm_writedata  = cur_pat;
         end
         S_READ: begin
            avm_address    = cnt_q;
            avm_byteenable = 4'hF;
            avm_chipselect = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      pat_d   = pat_q;
      pv_d    = 1'b0;
      pexp_d  = pexp_q;
      paddr_d = paddr_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
      done_d  = done_q;
      pass_d  = pass_q;

      if (accept) begin
         cnt_d  = '0;
         lfsr_d = SEED;
         pat_d  = pattern_sel;
         err_d  = 16'h0;
         ferr_d = '0;
         done_d = 1'b0;
         pass_d = 1'b0;
      end

      if (!abort && (state_q == S_WRITE || state_q == S_READ)) begin
         cnt_d  = is_last ? '0 : cnt_q + 1'b1;
         lfsr_d = lfsr_next(lfsr_q);
         // readback regenerates the same sequence from the seed
         if (state_q == S_WRITE && is_last) lfsr_d = SEED;
      end

      if (!abort && state_q == S_READ) begin
         pv_d    = 1'b1;
         pexp_d  = cur_pat;
         paddr_d = cnt_q;
      end

      if (mism) begin
         if (err_q != 16'hFFFF) err_d = err_q + 16'h1;
         if (err_q == 16'h0)    ferr_d = paddr_q;
      end

      if (abort && state_q != S_IDLE) begin
         done_d = 1'b0;
         pass_d = 1'b0;
      end else if (state_q == S_DRAIN) begin
         done_d = 1'b1;
         pass_d = (err_d == 16'h0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         lfsr_q  <= SEED;
         pat_q   <= 2'd0;
         pv_q    <= 1'b0;
         pexp_q  <= 32'h0;
         paddr_q <= '0;
         err_q   <= 16'h0;
         ferr_q  <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         clken_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         pat_q   <= pat_d;
         pv_q    <= pv_d;
         pexp_q  <= pexp_d;
         paddr_q <= paddr_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         clken_q <= 1'b1;
      end
   end

   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
   assign avm_clken      = clken_q;

endmodule

// File: tb/tb_sram_bist_master.sv
// Bench for sram_bist_master: SRAM model with read faults, expected
// end-of-test results queued at start and checked when done rises.
module tb_sram_bist_master;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [1:0]  pattern_sel;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [9:0]  first_err_addr;
   logic [9:0]  avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_chipselect;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_clken;
   logic [31:0] avm_readdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int fmode  = 0;

   logic [31:0] mem [0:1023];

   typedef struct {
      int          c0;
      logic [15:0] err;
      logic [9:0]  first;
      logic        pass;
   } exp_t;

   exp_t sbq[$];
   logic done_seen = 1'b0;

   sram_bist_master dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .abort          (abort),
      .pattern_sel    (pattern_sel),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .avm_address    (avm_address),
      .avm_byteenable (avm_byteenable),
      .avm_chipselect (avm_chipselect),
      .avm_write      (avm_write),
      .avm_writedata  (avm_writedata),
      .avm_clken      (avm_clken),
      .avm_readdata   (avm_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // fault modes: 1 bit3 stuck-1 @07F, 2 bit3 stuck-0 @07F, 3 reads 0
   always @(posedge clk) begin
      if (avm_chipselect && avm_write)
         mem[avm_address] <= avm_writedata;
      if (avm_chipselect && !avm_write) begin
         if (fmode == 3)
            avm_readdata <= 32'h0;
         else if (fmode == 1 && avm_address == 10'h07F)
            avm_readdata <= mem[avm_address] | 32'h8;
         else if (fmode == 2 && avm_address == 10'h07F)
            avm_readdata <= mem[avm_address] & ~32'h8;
         else
            avm_readdata <= mem[avm_address];
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done && !done_seen) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got 1 expected 0");
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("latency", 32'(cyc - e.c0 + 1), 32'd2050);
            chk("err_count", 32'(err_count), 32'(e.err));
            chk("first_err_addr", 32'(first_err_addr), 32'(e.first));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
      done_seen = done;
   end

   task automatic do_start(input logic [1:0] sel, output int c0);
      @(negedge clk);
      start       = 1'b1;
      pattern_sel = sel;
      @(posedge clk);
      #1;
      start       = 1'b0;
      pattern_sel = sel ^ 2'b01;
      c0          = cyc;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done_clr", 32'(done), 32'd0);
   endtask

   task automatic push(input int c0, input logic [15:0] err,
                       input logic [9:0] first, input logic ok);
      exp_t e;
      e.c0    = c0;
      e.err   = err;
      e.first = first;
      e.pass  = ok;
      sbq.push_back(e);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got 0 expected 1");
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int c0;
      int n;
      reset_n     = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      pattern_sel = 2'd0;
      #1;
      chk("reset_outputs", 32'(|{busy, done, pass, err_count,
          first_err_addr, avm_address, avm_byteenable, avm_chipselect,
          avm_write, avm_writedata, avm_clken}), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("clken_after_reset", 32'(avm_clken), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // address-in-data, ideal memory
      fmode = 0;
      do_start(2'd0, c0);
      push(c0, 16'd0, 10'd0, 1'b1);
      wait_done();
      chk("mem_word5", mem[5], 32'h00050005);
      chk("done_level", 32'(done), 32'd1);

      // stuck-1 on a bit the odd checkerboard word already holds high
      fmode = 1;
      do_start(2'd1, c0);
      push(c0, 16'd0, 10'd0, 1'b1);
      wait_done();

      fmode = 2;
      do_start(2'd1, c0);
      push(c0, 16'd1, 10'h07F, 1'b0);
      wait_done();

      fmode = 0;
      do_start(2'd2, c0);
      chk("lfsr_k0_data", avm_writedata, 32'hA5A55A5A);
      chk("lfsr_k0_ctrl", 32'({avm_chipselect, avm_write, avm_byteenable,
          avm_address}), 32'({1'b1, 1'b1, 4'hF, 10'd0}));
      @(posedge clk);
      #1;
      chk("lfsr_k1_data", avm_writedata, 32'h52D2AD2D);
      chk("lfsr_k1_addr", 32'(avm_address), 32'd1);
      push(c0, 16'd0, 10'd0, 1'b1);
      wait_done();

      fmode = 3;
      do_start(2'd3, c0);
      push(c0, 16'd1024, 10'd0, 1'b0);
      wait_done();

      // abort during readback
      fmode = 0;
      do_start(2'd0, c0);
      n = 0;
      while (!(avm_chipselect && !avm_write && avm_address == 10'd300)
             && n < 2500) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_k300", 32'(avm_address), 32'd300);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cs", 32'({avm_chipselect, avm_write}), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_err_hold", 32'(err_count), 32'd0);
      repeat (5) @(negedge clk);
      chk("abort_still_idle", 32'({busy, done}), 32'd0);
      do_start(2'd0, c0);
      push(c0, 16'd0, 10'd0, 1'b1);
      wait_done();

      // reset mid-WRITE, then a restart attempt while busy
      do_start(2'd1, c0);
      repeat (100) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_outputs", 32'(|{busy, done, pass, err_count,
          first_err_addr, avm_address, avm_byteenable, avm_chipselect,
          avm_write, avm_writedata, avm_clken}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("clken_after_midreset", 32'(avm_clken), 32'd1);
      do_start(2'd0, c0);
      push(c0, 16'd0, 10'd0, 1'b1);
      repeat (50) @(negedge clk);
      start       = 1'b1;
      pattern_sel = 2'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      chk("queue_empty", 32'(sbq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
